// File: rtl/ifid_queue.sv
// IF/ID fetch queue: DEPTH-entry circular buffer of {pc, instr} with valid/ready on both sides,
// whole-queue flush and a NOP bubble when empty. Define IFID_QUEUE_BYPASS_EN for a zero-latency empty path.
module ifid_queue #(
    parameter int                 WIDTH     = 32,
    parameter int                 DEPTH     = 2,
    parameter logic [WIDTH-1:0]   NOP_INSTR = 'h00000013
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       flush_in,
    input  logic                       in_valid_in,
    output logic                       in_ready_out,
    input  logic [WIDTH-1:0]           pc_in,
    input  logic [WIDTH-1:0]           instr_in,
    output logic                       out_valid_out,
    input  logic                       out_ready_in,
    output logic [WIDTH-1:0]           pc_out,
    output logic [WIDTH-1:0]           instr_out,
    output logic [$clog2(DEPTH):0]     count_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic has_data;
    logic bypass;
    logic consumed;
    logic push;
    logic pop;

    assign has_data     = (count != '0);
    // Ready looks only at registered occupancy, so a pop never frees a slot in the same cycle.
    assign in_ready_out = (count < CW'(DEPTH));

`ifdef IFID_QUEUE_BYPASS_EN
    assign bypass = !has_data && in_valid_in && !flush_in;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry taken by decode in the same cycle never touches storage.
    assign consumed = bypass && out_ready_in;
    assign push     = in_valid_in && in_ready_out && !flush_in && !consumed;
    assign pop      = has_data && out_ready_in && !flush_in;

    assign out_valid_out = has_data || bypass;
    assign count_out     = count;

    // NOTE: every output gets its default before the conditional overrides, so no latch is inferred.
    always_comb begin
        pc_out    = '0;
        instr_out = NOP_INSTR;
        if (has_data) begin
            pc_out    = pc_mem[rd_ptr];
            instr_out = instr_mem[rd_ptr];
        end else if (bypass) begin
            pc_out    = pc_in;
            instr_out = instr_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: entry storage has no reset; occupancy and pointers alone decide what is visible.
    always_ff @(posedge clk_in) begin
        if (push) begin
            pc_mem[wr_ptr]    <= pc_in;
            instr_mem[wr_ptr] <= instr_in;
        end
    end

    occupancy_bounded: assert property (@(posedge clk_in) disable iff (!rst_in) count <= CW'(DEPTH));

endmodule

// File: tb/tb_ifid_queue.sv
// Directed bench for ifid_queue (default build, DEPTH=2): reset, ordering, full, flush, wrap and async reset.
module tb_ifid_queue;

    localparam int          WIDTH = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        flush_in;
    logic        in_valid_in;
    logic        in_ready_out;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        out_valid_out;
    logic        out_ready_in;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic [1:0]  count_out;

    int tests_run    = 0;
    int tests_failed = 0;

    // Observed tuple: {valid, pc, instr, count, ready}
    logic [67:0] got;
    logic [67:0] exp;

    ifid_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .flush_in      (flush_in),
        .in_valid_in   (in_valid_in),
        .in_ready_out  (in_ready_out),
        .pc_in         (pc_in),
        .instr_in      (instr_in),
        .out_valid_out (out_valid_out),
        .out_ready_in  (out_ready_in),
        .pc_out        (pc_out),
        .instr_out     (instr_out),
        .count_out     (count_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [67:0] snapshot();
        return {out_valid_out, pc_out, instr_out, count_out, in_ready_out};
    endfunction

    function automatic logic [67:0] tup(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                                        input logic [1:0] cnt, input logic rdy);
        return {v, pc, ins, cnt, rdy};
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        in_valid_in = v;
        pc_in       = pc;
        instr_in    = ins;
    endtask

    task automatic test_reset();
        #2;
        got = snapshot(); exp = tup(1'b0, 32'h0, NOP, 2'd0, 1'b1); tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL reset_held: got %h expected %h", got, exp); end
        step();
        rst_in = 1'b1;
        step();
        got = snapshot(); tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL reset_idle: got %h expected %h", got, exp); end
    endtask

    task automatic test_single();
        out_ready_in = 1'b1;
        offer(1'b1, 32'h100, 32'hAAAA0001);
        #1;
        got = snapshot(); exp = tup(1'b0, 32'h0, NOP, 2'd0, 1'b1); tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL single_no_fallthrough: got %h expected %h", got, exp); end
        step();
        offer(1'b0, 32'h0, 32'h0);
        got = snapshot(); exp = tup(1'b1, 32'h100, 32'hAAAA0001, 2'd1, 1'b1); tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL single_visible: got %h expected %h", got, exp); end
        step();
        got = snapshot(); exp = tup(1'b0, 32'h0, NOP, 2'd0, 1'b1); tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL single_popped: got %h expected %h", got, exp); end
    endtask

    task automatic test_fill_order();
        out_ready_in = 1'b0;
        offer(1'b1, 32'h100, 32'hC000_0100);
        step();
        offer(1'b1, 32'h104, 32'hC000_0104);
        step();
        offer(1'b1, 32'h108, 32'hC000_0108);
        got = snapshot(); exp = tup(1'b1, 32'h100, 32'hC000_0100, 2'd2, 1'b0); tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL fill_full: got %h expected %h", got, exp); end
        step();
        offer(1'b0, 32'h0, 32'h0);
        got = snapshot(); tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL fill_refused_third: got %h expected %h", got, exp); end
        out_ready_in = 1'b1;
        step();
        got = snapshot(); exp = tup(1'b1, 32'h104, 32'hC000_0104, 2'd1, 1'b1); tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL fill_second_out: got %h expected %h", got, exp); end
        step();
        got = snapshot(); exp = tup(1'b0, 32'h0, NOP, 2'd0, 1'b1); tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL fill_drained: got %h expected %h", got, exp); end
    endtask

    task automatic test_full_pop_push();
        out_ready_in = 1'b0;
        offer(1'b1, 32'h300, 32'hD000_0300);
        step();
        offer(1'b1, 32'h304, 32'hD000_0304);
        step();
        offer(1'b1, 32'h308, 32'hD000_0308);
        out_ready_in = 1'b1;
        got = snapshot(); exp = tup(1'b1, 32'h300, 32'hD000_0300, 2'd2, 1'b0); tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL full_offer: got %h expected %h", got, exp); end
        step();
        out_ready_in = 1'b0;
        got = snapshot(); exp = tup(1'b1, 32'h304, 32'hD000_0304, 2'd1, 1'b1); tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL full_pop_no_push: got %h expected %h", got, exp); end
        step();
        offer(1'b0, 32'h0, 32'h0);
        got = snapshot(); exp = tup(1'b1, 32'h304, 32'hD000_0304, 2'd2, 1'b0); tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL full_push_next: got %h expected %h", got, exp); end
        out_ready_in = 1'b1;
        step();
        got = snapshot(); exp = tup(1'b1, 32'h308, 32'hD000_0308, 2'd1, 1'b1); tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL full_late_entry: got %h expected %h", got, exp); end
        step();
    endtask

    task automatic test_flush();
        out_ready_in = 1'b0;
        offer(1'b1, 32'h400, 32'hE000_0400);
        step();
        offer(1'b1, 32'h404, 32'hE000_0404);
        step();
        offer(1'b1, 32'h408, 32'hE000_0408);
        out_ready_in = 1'b1;
        flush_in     = 1'b1;
        step();
        flush_in = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        out_ready_in = 1'b0;
        got = snapshot(); exp = tup(1'b0, 32'h0, NOP, 2'd0, 1'b1); tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL flush_empty: got %h expected %h", got, exp); end
        flush_in = 1'b1;
        #1;
        tests_run++;
        if (in_ready_out !== 1'b1) begin tests_failed++; $display("FAIL flush_ready_ungated: got %b expected 1", in_ready_out); end
        flush_in = 1'b0;
        offer(1'b1, 32'h200, 32'hE000_0200);
        step();
        offer(1'b0, 32'h0, 32'h0);
        got = snapshot(); exp = tup(1'b1, 32'h200, 32'hE000_0200, 2'd1, 1'b1); tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL flush_next_push: got %h expected %h", got, exp); end
        out_ready_in = 1'b1;
        step();
        got = snapshot(); exp = tup(1'b0, 32'h0, NOP, 2'd0, 1'b1); tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL flush_after_drain: got %h expected %h", got, exp); end
    endtask

    task automatic test_wrap_reset();
        out_ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            offer(1'b1, 32'(i * 4), 32'hB000_0000 + 32'(i));
            step();
            got = snapshot(); exp = tup(1'b1, 32'(i * 4), 32'hB000_0000 + 32'(i), 2'd1, 1'b1); tests_run++;
            if (got !== exp) begin tests_failed++; $display("FAIL wrap_item%0d: got %h expected %h", i, got, exp); end
        end
        out_ready_in = 1'b0;
        offer(1'b1, 32'h14, 32'hB000_0005);
        step();
        offer(1'b0, 32'h0, 32'h0);
        got = snapshot(); exp = tup(1'b1, 32'h10, 32'hB000_0004, 2'd2, 1'b0); tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL wrap_midstream: got %h expected %h", got, exp); end
        #2;
        rst_in = 1'b0;
        #1;
        got = snapshot(); exp = tup(1'b0, 32'h0, NOP, 2'd0, 1'b1); tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL async_reset: got %h expected %h", got, exp); end
        step();
        rst_in       = 1'b1;
        out_ready_in = 1'b1;
        step();
        got = snapshot(); tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL reset_release: got %h expected %h", got, exp); end
    endtask

    initial begin
        rst_in       = 1'b0;
        flush_in     = 1'b0;
        out_ready_in = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        test_reset();
        test_single();
        test_fill_order();
        test_full_pop_push();
        test_flush();
        test_wrap_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
